// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the MEM-stage load/store unit (lsu_rmw):
//   - RV64 load/store funct3 encodings
//   - control state encoding for the read-modify-write sequence
//   - helpers that turn a funct3 into an access size and a byte-lane mask
// ---------------------------------------------------------------------------
package lsu_pkg;

  // RV64 funct3 encodings for loads and stores. Bit 2 marks the unsigned
  // (zero-extending) load variants; it is never legal on a store.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // IDLE accepts new requests; RMW_WRITE commits a merged doubleword.
  typedef enum logic {
    IDLE      = 1'b0,
    RMW_WRITE = 1'b1
  } lsu_state_e;

  // Access size in bytes. Only funct3[1:0] matters; 111 aliases to 8 here
  // and is rejected separately by the error check.
  function automatic logic [3:0] f3_size(input logic [2:0] f3);
    logic [3:0] sz;
    case (f3[1:0])
      2'b00:   sz = 4'd1;
      2'b01:   sz = 4'd2;
      2'b10:   sz = 4'd4;
      default: sz = 4'd8;
    endcase
    return sz;
  endfunction

  // Low-aligned byte-lane mask covering 'sz' bytes.
  function automatic logic [63:0] size_mask(input logic [3:0] sz);
    logic [63:0] m;
    case (sz)
      4'd1:    m = 64'h0000_0000_0000_00FF;
      4'd2:    m = 64'h0000_0000_0000_FFFF;
      4'd4:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_rmw_load_extract.sv
// ---------------------------------------------------------------------------
// load_extract
//   Combinational load alignment: selects the addressed bytes out of a
//   little-endian doubleword and sign- or zero-extends them to 64 bits.
//
// Ports
//   dword_i  [63:0]  doubleword read from memory at the aligned base
//   off_i    [2:0]   byte offset of the access within the doubleword
//   funct3_i [2:0]   RV load funct3 (B/H/W/D/BU/HU/WU)
//   result_o [63:0]  extended load result
// ---------------------------------------------------------------------------
module load_extract
  import lsu_pkg::*;
(
  input  logic [63:0] dword_i,
  input  logic [2:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] result_o
);

  // Move the addressed byte to lane 0; alignment has already been checked
  // upstream, so the selected field never straddles the doubleword.
  logic [63:0] shifted;
  assign shifted = dword_i >> {off_i, 3'b000};

  always_comb begin
    result_o = shifted;
    case (funct3_i)
      F3_B:    result_o = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    result_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    result_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    result_o = shifted;
      F3_BU:   result_o = {56'd0, shifted[7:0]};
      F3_HU:   result_o = {48'd0, shifted[15:0]};
      F3_WU:   result_o = {32'd0, shifted[31:0]};
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// ---------------------------------------------------------------------------
// lsu_rmw
//   MEM-stage load/store unit sitting between the EX/MEM register and a
//   byte-addressed 64-bit data memory that only takes aligned doubleword
//   accesses. Loads and SD complete in one cycle; SB/SH/SW read the
//   doubleword, merge the new bytes, and write it back one cycle later
//   while the front of the pipeline is stalled for the read cycle.
//
// Parameters
//   MEM_BYTES  data memory size in bytes (multiple of 8)
//   ADDR_W     width of the request address
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   req_load, req_store           request strobes from EX/MEM
//   funct3                        access size / signedness
//   req_addr                      byte address
//   req_wdata                     store data (low bytes significant)
//   stall                         hold PC, IF/ID, ID/EX and EX/MEM
//   load_data, load_valid         registered load result for MEM/WB
//   access_err                    registered illegal-request flag
//   mem_address, mem_write_data   to the data memory
//   mem_memorywrite               memory write enable (writes on posedge)
//   mem_memoryread                memory read enable (combinational read)
//   mem_read_data                 combinational little-endian read data
// ---------------------------------------------------------------------------
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              stall,
  output logic [63:0]       load_data,
  output logic              load_valid,
  output logic              access_err,
  output logic [63:0]       mem_address,
  output logic [63:0]       mem_write_data,
  output logic              mem_memorywrite,
  output logic              mem_memoryread,
  input  logic [63:0]       mem_read_data
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [63:0]       merged_q, merged_d;
  logic [63:0]       load_data_q;
  logic              load_valid_q;
  logic              access_err_q;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] base;
  logic [2:0]        off;
  logic [3:0]        size;
  logic              has_req;
  logic              misaligned;
  logic              out_of_range;
  logic              bad_f3;
  logic              illegal;
  logic              req_ok;
  logic              legal_load;
  logic              legal_sd;
  logic              legal_rmw;

  assign base = {req_addr[ADDR_W-1:3], 3'b000};
  assign off  = req_addr[2:0];
  assign size = f3_size(funct3);

  assign has_req    = req_load | req_store;
  // size is a power of two, so the low bits of off must be clear.
  assign misaligned = (({1'b0, off} & (size - 4'd1)) != 4'd0);
  // base is 8-aligned, so base+7 cannot wrap around the address space.
  assign out_of_range = ((base + ADDR_W'(7)) >= ADDR_W'(MEM_BYTES));
  assign bad_f3     = (funct3 == 3'b111) || (req_store && funct3[2]);

  // Requests are only evaluated in IDLE; during RMW_WRITE the held EX/MEM
  // request is the one being completed and must not be re-checked.
  assign illegal = (state_q == IDLE) && has_req &&
                   (misaligned || out_of_range || (req_load && req_store) || bad_f3);
  assign req_ok  = (state_q == IDLE) && has_req && !illegal;

  assign legal_load = req_ok && req_load;
  assign legal_sd   = req_ok && req_store && (funct3 == F3_D);
  assign legal_rmw  = req_ok && req_store && (funct3 != F3_D);

  // ---------------------------------------------------------------------
  // Store merge: replace the addressed byte lanes of the read doubleword
  // ---------------------------------------------------------------------
  logic [63:0] lane_mask;
  logic [63:0] wdata_shifted;

  assign lane_mask     = size_mask(size) << {off, 3'b000};
  assign wdata_shifted = req_wdata << {off, 3'b000};
  assign merged_d      = (mem_read_data & ~lane_mask) | (wdata_shifted & lane_mask);

  // ---------------------------------------------------------------------
  // Load extraction
  // ---------------------------------------------------------------------
  logic [63:0] load_ext;

  load_extract u_load_extract (
    .dword_i  (mem_read_data),
    .off_i    (off),
    .funct3_i (funct3),
    .result_o (load_ext)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (legal_rmw) state_d = RMW_WRITE;
      end
      RMW_WRITE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs to the memory and pipeline
  // ---------------------------------------------------------------------
  always_comb begin
    stall           = 1'b0;
    mem_memorywrite = 1'b0;
    mem_memoryread  = 1'b0;
    mem_address     = 64'(base);
    mem_write_data  = req_wdata;
    case (state_q)
      IDLE: begin
        if (legal_load) mem_memoryread = 1'b1;
        if (legal_sd)   mem_memorywrite = 1'b1;
        if (legal_rmw) begin
          mem_memoryread = 1'b1;
          stall          = 1'b1;
        end
      end
      RMW_WRITE: begin
        mem_memorywrite = 1'b1;
        mem_address     = 64'(base_q);
        mem_write_data  = merged_q;
      end
      default: ;
    endcase
    // While reset is held the EX/MEM register may still present a request;
    // nothing may reach the memory or stall the pipeline until it drops.
    if (reset) begin
      stall           = 1'b0;
      mem_memorywrite = 1'b0;
      mem_memoryread  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Read-modify-write holding registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      merged_q <= '0;
    end else if (legal_rmw) begin
      base_q   <= base;
      merged_q <= merged_d;
    end
  end

  // ---------------------------------------------------------------------
  // Writeback registers: load result and error flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      access_err_q <= 1'b0;
    end else begin
      load_valid_q <= legal_load;
      access_err_q <= illegal;
      if (legal_load) load_data_q <= load_ext;
    end
  end

  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign access_err = access_err_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// ---------------------------------------------------------------------------
// tb_lsu_rmw
//   Directed bench for lsu_rmw with a 64-byte behavioural data memory
//   (combinational read, posedge write). Inputs change on the falling edge;
//   outputs are sampled on the falling edge or 1 time unit after it.
// ---------------------------------------------------------------------------
module tb_lsu_rmw;
  import lsu_pkg::*;

  localparam int MB = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_load = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        stall;
  logic [63:0] load_data;
  logic        load_valid;
  logic        access_err;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_memorywrite;
  logic        mem_memoryread;
  logic [63:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  lsu_rmw #(.MEM_BYTES(MB), .ADDR_W(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_load        (req_load),
    .req_store       (req_store),
    .funct3          (funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .stall           (stall),
    .load_data       (load_data),
    .load_valid      (load_valid),
    .access_err      (access_err),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_memorywrite (mem_memorywrite),
    .mem_memoryread  (mem_memoryread),
    .mem_read_data   (mem_read_data)
  );

  always #5 clk = ~clk;

  // Behavioural data memory
  logic [7:0]  mem [0:MB-1];
  int          wr_cnt = 0;
  logic [63:0] last_wa = '0;
  logic [5:0]  ra;

  assign ra = mem_address[5:0] & 6'h38;
  assign mem_read_data = {mem[ra+6'd7], mem[ra+6'd6], mem[ra+6'd5], mem[ra+6'd4],
                          mem[ra+6'd3], mem[ra+6'd2], mem[ra+6'd1], mem[ra]};

  always @(posedge clk) begin
    if (mem_memorywrite) begin
      for (int k = 0; k < 8; k++) mem[int'(ra) + k] <= mem_write_data[8*k +: 8];
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_address;
    end
  end

  function automatic logic [63:0] dw(input int a);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = mem[a + k];
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic ld, input logic st, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] wd);
    req_load  = ld;
    req_store = st;
    funct3    = f3;
    req_addr  = a;
    req_wdata = wd;
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 3'b000, 64'd0, 64'd0);
  endtask

  int wc;

  initial begin
    for (int i = 0; i < MB; i++) mem[i] <= 8'h00;
    for (int i = 0; i < 8; i++) mem[8 + i] <= 8'(8'h11 * (i + 1));

    // Reset state
    @(negedge clk); #1;
    check("rst_load_data", load_data, 64'd0);
    check("rst_load_valid", load_valid, 1'b0);
    check("rst_access_err", access_err, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_memwrite", mem_memorywrite, 1'b0);
    check("rst_memread", mem_memoryread, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_stall", stall, 1'b0);
    check("idle_memread", mem_memoryread, 1'b0);

    // LB 15, then LBU 15
    @(negedge clk);
    req(1'b1, 1'b0, F3_B, 64'd15, 64'd0);
    #1;
    check("lb_memread", mem_memoryread, 1'b1);
    check("lb_addr", mem_address, 64'd8);
    check("lb_stall", stall, 1'b0);
    @(negedge clk);
    check("lb_data", load_data, 64'hFFFF_FFFF_FFFF_FF88);
    check("lb_valid", load_valid, 1'b1);
    check("lb_err", access_err, 1'b0);
    req(1'b1, 1'b0, F3_BU, 64'd15, 64'd0);
    @(negedge clk);
    check("lbu_data", load_data, 64'h0000_0000_0000_0088);
    check("lbu_valid", load_valid, 1'b1);

    // SB 0xAB to 10: read cycle with stall, then one merged write
    wc = wr_cnt;
    req(1'b0, 1'b1, F3_B, 64'd10, 64'h0000_0000_0000_00AB);
    #1;
    check("sb_rd_stall", stall, 1'b1);
    check("sb_rd_memread", mem_memoryread, 1'b1);
    check("sb_rd_memwrite", mem_memorywrite, 1'b0);
    check("sb_rd_addr", mem_address, 64'd8);
    @(negedge clk);
    check("sb_wr_stall", stall, 1'b0);
    check("sb_wr_memwrite", mem_memorywrite, 1'b1);
    check("sb_wr_addr", mem_address, 64'd8);
    check("sb_wr_data", mem_write_data, 64'h8877_6655_44AB_2211);
    check("sb_load_valid", load_valid, 1'b0);
    @(negedge clk);
    check("sb_mem", dw(8), 64'h8877_6655_44AB_2211);
    check("sb_wr_cnt", 64'(wr_cnt), 64'(wc + 1));
    check("sb_last_wa", last_wa, 64'd8);

    // SD to 16, LW 20, LH 22
    req(1'b0, 1'b1, F3_D, 64'd16, 64'h0123_4567_89AB_CDEF);
    #1;
    check("sd_stall", stall, 1'b0);
    check("sd_memwrite", mem_memorywrite, 1'b1);
    check("sd_addr", mem_address, 64'd16);
    @(negedge clk);
    check("sd_mem", dw(16), 64'h0123_4567_89AB_CDEF);
    req(1'b1, 1'b0, F3_W, 64'd20, 64'd0);
    #1;
    check("lw20_stall", stall, 1'b0);
    @(negedge clk);
    check("lw20_data", load_data, 64'h0000_0000_0123_4567);
    check("lw20_err", access_err, 1'b0);
    req(1'b1, 1'b0, F3_H, 64'd22, 64'd0);
    #1;
    check("lh22_stall", stall, 1'b0);
    @(negedge clk);
    check("lh22_data", load_data, 64'h0000_0000_0000_0123);
    check("lh22_valid", load_valid, 1'b1);

    // Illegal requests: misaligned LW, misaligned SH, out-of-range LD
    wc = wr_cnt;
    req(1'b1, 1'b0, F3_W, 64'd6, 64'd0);
    #1;
    check("lw6_memwrite", mem_memorywrite, 1'b0);
    check("lw6_stall", stall, 1'b0);
    @(negedge clk);
    check("lw6_err", access_err, 1'b1);
    check("lw6_valid", load_valid, 1'b0);
    check("lw6_data_held", load_data, 64'h0000_0000_0000_0123);
    req(1'b0, 1'b1, F3_H, 64'd3, 64'h0000_0000_0000_FFFF);
    #1;
    check("sh3_memwrite", mem_memorywrite, 1'b0);
    check("sh3_stall", stall, 1'b0);
    @(negedge clk);
    check("sh3_err", access_err, 1'b1);
    check("sh3_valid", load_valid, 1'b0);
    req(1'b1, 1'b0, F3_D, 64'd64, 64'd0);
    #1;
    check("ld64_memwrite", mem_memorywrite, 1'b0);
    check("ld64_stall", stall, 1'b0);
    @(negedge clk);
    check("ld64_err", access_err, 1'b1);
    check("ld64_valid", load_valid, 1'b0);
    check("illegal_wr_cnt", 64'(wr_cnt), 64'(wc));
    check("illegal_mem0", dw(0), 64'd0);
    check("illegal_mem8", dw(8), 64'h8877_6655_44AB_2211);
    check("illegal_mem16", dw(16), 64'h0123_4567_89AB_CDEF);

    // SW 0xDEADBEEF to 0, then LWU 0 right after, then LW 0
    req(1'b0, 1'b1, F3_W, 64'd0, 64'h0000_0000_DEAD_BEEF);
    #1;
    check("sw_rd_stall", stall, 1'b1);
    @(negedge clk);
    check("sw_err_cleared", access_err, 1'b0);
    check("sw_wr_data", mem_write_data, 64'h0000_0000_DEAD_BEEF);
    check("sw_wr_stall", stall, 1'b0);
    @(negedge clk);
    req(1'b1, 1'b0, F3_WU, 64'd0, 64'd0);
    #1;
    check("lwu_stall", stall, 1'b0);
    check("lwu_memread", mem_memoryread, 1'b1);
    @(negedge clk);
    check("lwu_data", load_data, 64'h0000_0000_DEAD_BEEF);
    check("lwu_valid", load_valid, 1'b1);
    req(1'b1, 1'b0, F3_W, 64'd0, 64'd0);
    @(negedge clk);
    check("lw0_data", load_data, 64'hFFFF_FFFF_DEAD_BEEF);

    // Reset asserted during RMW_WRITE of SB to 2
    wc = wr_cnt;
    req(1'b0, 1'b1, F3_B, 64'd2, 64'h0000_0000_0000_005A);
    #1;
    check("sbr_rd_stall", stall, 1'b1);
    @(negedge clk); #1;
    check("sbr_wr_memwrite", mem_memorywrite, 1'b1);
    reset = 1'b1;
    #1;
    check("sbr_rst_memwrite", mem_memorywrite, 1'b0);
    check("sbr_rst_stall", stall, 1'b0);
    check("sbr_rst_state", 64'(dut.state_q), 64'(IDLE));
    check("sbr_rst_load_data", load_data, 64'd0);
    check("sbr_rst_load_valid", load_valid, 1'b0);
    check("sbr_rst_access_err", access_err, 1'b0);
    @(negedge clk);
    check("sbr_mem0", dw(0), 64'h0000_0000_DEAD_BEEF);
    check("sbr_wr_cnt", 64'(wr_cnt), 64'(wc));
    idle();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_stall", stall, 1'b0);
    check("post_rst_memwrite", mem_memorywrite, 1'b0);
    check("post_rst_memread", mem_memoryread, 1'b0);
    check("post_rst_valid", load_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
